// File: rtl/la_iocfg_loader_pkg.sv
// -----------------------------------------------------------------------------
// la_iocfg_pkg
// Shared definitions for the padring configuration loader:
//   - commit FSM state encoding (IDLE / QUIESCE / APPLY)
//   - per-pin record field offsets inside the shadow chain
//   - helpers that size the record, the whole chain and the bit counter
// No ports; imported by every design file of the loader.
// -----------------------------------------------------------------------------
package la_iocfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUIESCE = 2'd1,
        ST_APPLY   = 2'd2
    } state_t;

    // Field offsets inside one pin record {cfg, oe, ie}
    localparam int IE_BIT  = 0;
    localparam int OE_BIT  = 1;
    localparam int CFG_LSB = 2;

    function automatic int recWidth(input int cfgw);
        return cfgw + 2;
    endfunction

    function automatic int chainLen(input int npins, input int cfgw);
        return npins * recWidth(cfgw);
    endfunction

    // The counter must reach LEN+1 so that an overshift stays distinguishable
    function automatic int countWidth(input int npins, input int cfgw);
        return $clog2(chainLen(npins, cfgw) + 2);
    endfunction

endpackage

// File: rtl/la_iocfg_loader_if.sv
// -----------------------------------------------------------------------------
// la_iocfg_if
// Bundle between a configuration source (master) and the loader (slave).
//   shift_en, sdi, update, capture : source -> loader
//   sdo, busy, done, err           : loader -> source
//   ie, oe (NPINS), cfg (NPINS*CFGW): loader -> pads (read on master side)
// -----------------------------------------------------------------------------
interface la_iocfg_if #(
    parameter int NPINS = 4,
    parameter int CFGW  = 8
);
    logic                    shift_en;
    logic                    sdi;
    logic                    sdo;
    logic                    update;
    logic                    capture;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic [NPINS-1:0]        ie;
    logic [NPINS-1:0]        oe;
    logic [NPINS*CFGW-1:0]   cfg;

    modport master (
        output shift_en, sdi, update, capture,
        input  sdo, busy, done, err, ie, oe, cfg
    );

    modport slave (
        input  shift_en, sdi, update, capture,
        output sdo, busy, done, err, ie, oe, cfg
    );
endinterface

// File: rtl/la_iocfg_loader_chain.sv
// -----------------------------------------------------------------------------
// la_iocfg_chain
// Shadow shift register with its saturating bit counter and capture mux.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   i_shift      : shift one bit in at the MSB (LSB leaves first)
//   i_sdi        : serial data in
//   i_capture    : load i_active into the shadow and mark the chain full
//   i_clear      : zero the bit counter (bad update or completed commit)
//   i_active     : packed active records, same layout as the shadow
//   o_shadow     : current shadow contents
//   o_count      : bits shifted since the last clear, saturating at LEN+1
// The controller guarantees the control inputs are only raised when legal.
// -----------------------------------------------------------------------------
module la_iocfg_chain
    import la_iocfg_pkg::*;
#(
    parameter int NPINS = 4,
    parameter int CFGW  = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   i_shift,
    input  logic                                   i_sdi,
    input  logic                                   i_capture,
    input  logic                                   i_clear,
    input  logic [chainLen(NPINS, CFGW)-1:0]       i_active,
    output logic [chainLen(NPINS, CFGW)-1:0]       o_shadow,
    output logic [countWidth(NPINS, CFGW)-1:0]     o_count
);

    localparam int LEN  = chainLen(NPINS, CFGW);
    localparam int CNTW = countWidth(NPINS, CFGW);
    localparam logic [CNTW-1:0] CNT_LEN = CNTW'(LEN);
    localparam logic [CNTW-1:0] CNT_SAT = CNTW'(LEN + 1);

    logic [LEN-1:0]  r_shadow;
    logic [CNTW-1:0] r_count;

    // Clearing only touches the counter; the shadow keeps its last image so
    // a failed update leaves sdo readable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_capture) begin
            r_shadow <= i_active;
            r_count  <= CNT_LEN;
        end else if (i_shift) begin
            r_shadow <= {i_sdi, r_shadow[LEN-1:1]};
            if (r_count != CNT_SAT) begin
                r_count <= r_count + CNTW'(1);
            end
        end
    end

    assign o_shadow = r_shadow;
    assign o_count  = r_count;

endmodule

// File: rtl/la_iocfg_loader.sv
// -----------------------------------------------------------------------------
// la_iocfg_loader
// Serial loader for per-pin ie/oe/cfg pad controls with break-before-make
// commits: changed pins have oe forced low for HOLDCYC cycles before the new
// records become active.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : la_iocfg_if slave (shift_en, sdi, sdo, update, capture,
//                busy, done, err, ie, oe, cfg)
// Parameters: NPINS, CFGW, HOLDCYC (>=1)
// Build option: LA_IOCFG_READBACK_EN enables capture of the active records
// into the shadow chain; without it capture is ignored.
// -----------------------------------------------------------------------------
module la_iocfg_loader
    import la_iocfg_pkg::*;
#(
    parameter int NPINS   = 4,
    parameter int CFGW    = 8,
    parameter int HOLDCYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    la_iocfg_if.slave   bus
);

    localparam int RECW  = recWidth(CFGW);
    localparam int LEN   = chainLen(NPINS, CFGW);
    localparam int CNTW  = countWidth(NPINS, CFGW);
    localparam int HOLDW = $clog2(HOLDCYC + 1);

    state_t                 r_state;
    logic [HOLDW-1:0]       r_hold;
    logic [NPINS-1:0]       r_mask;
    logic [NPINS-1:0]       r_ie;
    logic [NPINS-1:0]       r_oe;
    logic [NPINS*CFGW-1:0]  r_cfg;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;

    logic [LEN-1:0]         w_shadow;
    logic [CNTW-1:0]        w_count;
    logic [LEN-1:0]         w_activeRec;
    logic [NPINS-1:0]       w_diff;
    logic [NPINS-1:0]       w_newIe;
    logic [NPINS-1:0]       w_newOe;
    logic [NPINS*CFGW-1:0]  w_newCfg;
    logic                   w_idle;
    logic                   w_countOk;
    logic                   w_shift;
    logic                   w_clear;
    logic                   w_capture;

    // Pack the active registers into chain layout, unpack the shadow into
    // pad fields, and flag every pin whose record is about to change.
    always_comb begin
        w_activeRec = '0;
        w_diff      = '0;
        w_newIe     = '0;
        w_newOe     = '0;
        w_newCfg    = '0;
        for (int p = 0; p < NPINS; p++) begin
            w_activeRec[p*RECW + IE_BIT]           = r_ie[p];
            w_activeRec[p*RECW + OE_BIT]           = r_oe[p];
            w_activeRec[p*RECW + CFG_LSB +: CFGW]  = r_cfg[p*CFGW +: CFGW];
            w_newIe[p]                             = w_shadow[p*RECW + IE_BIT];
            w_newOe[p]                             = w_shadow[p*RECW + OE_BIT];
            w_newCfg[p*CFGW +: CFGW]               = w_shadow[p*RECW + CFG_LSB +: CFGW];
            w_diff[p] = (w_shadow[p*RECW +: RECW] != w_activeRec[p*RECW +: RECW]);
        end
    end

    // Update has priority over shift and capture; nothing touches the shadow
    // outside IDLE, so the image being committed is frozen.
    assign w_idle    = (r_state == ST_IDLE);
    assign w_countOk = (w_count == CNTW'(LEN));
    assign w_shift   = w_idle & bus.shift_en & ~bus.update;
    assign w_clear   = (w_idle & bus.update & ~w_countOk) | (r_state == ST_APPLY);

`ifdef LA_IOCFG_READBACK_EN
    assign w_capture = w_idle & bus.capture & ~bus.update;
`else
    logic w_unusedCapture;
    assign w_capture       = 1'b0;
    assign w_unusedCapture = bus.capture;
`endif

    la_iocfg_chain #(
        .NPINS (NPINS),
        .CFGW  (CFGW)
    ) u_chain (
        .clk       (clk),
        .reset     (reset),
        .i_shift   (w_shift),
        .i_sdi     (bus.sdi),
        .i_capture (w_capture),
        .i_clear   (w_clear),
        .i_active  (w_activeRec),
        .o_shadow  (w_shadow),
        .o_count   (w_count)
    );

    // Commit FSM: mask changed pins, hold for HOLDCYC cycles, then apply the
    // whole shadow in one edge so a partial commit is never visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
            r_mask  <= '0;
            r_ie    <= '1;
            r_oe    <= '0;
            r_cfg   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.update) begin
                        if (w_countOk) begin
                            r_state <= ST_QUIESCE;
                            r_mask  <= w_diff;
                            r_hold  <= HOLDW'(HOLDCYC - 1);
                            r_busy  <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_QUIESCE: begin
                    if (r_hold == '0) begin
                        r_state <= ST_APPLY;
                    end else begin
                        r_hold <= r_hold - HOLDW'(1);
                    end
                end
                ST_APPLY: begin
                    r_ie    <= w_newIe;
                    r_oe    <= w_newOe;
                    r_cfg   <= w_newCfg;
                    r_mask  <= '0;
                    r_err   <= 1'b0;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_mask  <= '0;
                end
            endcase
        end
    end

    assign bus.sdo  = w_shadow[0];
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.err  = r_err;
    assign bus.ie   = r_ie;
    assign bus.oe   = r_oe & ~r_mask;
    assign bus.cfg  = r_cfg;

endmodule

// File: tb/tb_la_iocfg_loader.sv
// -----------------------------------------------------------------------------
// tb_la_iocfg_loader
// Directed bench for la_iocfg_loader with NPINS=4, CFGW=8, HOLDCYC=2.
// Inputs change 1 time unit after each rising edge and outputs are sampled at
// the same point, so cycle k below means "after the k-th edge since update".
// -----------------------------------------------------------------------------
module tb_la_iocfg_loader;

    localparam int NPINS   = 4;
    localparam int CFGW    = 8;
    localparam int HOLDCYC = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    la_iocfg_if #(.NPINS(NPINS), .CFGW(CFGW)) bus ();

    la_iocfg_loader #(
        .NPINS   (NPINS),
        .CFGW    (CFGW),
        .HOLDCYC (HOLDCYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int passCount  = 0;
    int checkCount = 0;
    int failCount  = 0;

    logic [39:0] imgA, imgA2, imgB, imgC, imgD, imgE, imgF;

    function automatic logic [9:0] rec(input logic [7:0] c, input logic o, input logic i);
        return {c, o, i};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock cycle with the given inputs, then return inputs to idle
    task automatic applyStimulus(input logic sh, input logic d, input logic upd,
                                 input logic cap);
        bus.shift_en = sh;
        bus.sdi      = d;
        bus.update   = upd;
        bus.capture  = cap;
        @(posedge clk);
        #1;
        bus.shift_en = 1'b0;
        bus.sdi      = 1'b0;
        bus.update   = 1'b0;
        bus.capture  = 1'b0;
    endtask

    task automatic shiftBits(input logic [39:0] img, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, img[i % 40], 1'b0, 1'b0);
        end
    endtask

    // Shift a full image, update, and return in cycle 4 (apply visible)
    task automatic commitImage(input logic [39:0] img);
        shiftBits(img, 40);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        imgA  = {rec(8'h00,1'b0,1'b1), rec(8'hA5,1'b1,1'b0), rec(8'h00,1'b0,1'b1), rec(8'h00,1'b0,1'b1)};
        imgA2 = {rec(8'h00,1'b0,1'b1), rec(8'hA5,1'b1,1'b0), rec(8'h00,1'b0,1'b1), rec(8'h11,1'b1,1'b1)};
        imgB  = {rec(8'h00,1'b0,1'b1), rec(8'h3C,1'b1,1'b0), rec(8'h00,1'b0,1'b1), rec(8'h11,1'b1,1'b1)};
        imgC  = {rec(8'h00,1'b0,1'b1), rec(8'h3C,1'b1,1'b0), rec(8'h5A,1'b0,1'b1), rec(8'h11,1'b1,1'b1)};
        imgD  = {rec(8'h00,1'b0,1'b1), rec(8'h3C,1'b1,1'b0), rec(8'h5A,1'b0,1'b1), rec(8'h11,1'b0,1'b1)};
        imgE  = {rec(8'hFF,1'b1,1'b1), rec(8'hFF,1'b1,1'b1), rec(8'hFF,1'b1,1'b1), rec(8'hFF,1'b1,1'b1)};
        imgF  = {rec(8'h81,1'b0,1'b1), rec(8'h42,1'b1,1'b0), rec(8'h24,1'b0,1'b0), rec(8'h18,1'b1,1'b1)};

        bus.shift_en = 1'b0;
        bus.sdi      = 1'b0;
        bus.update   = 1'b0;
        bus.capture  = 1'b0;
        reset        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] reset values");
        checkOutput("rst ie",   bus.ie,   4'hF);
        checkOutput("rst oe",   bus.oe,   4'h0);
        checkOutput("rst cfg",  bus.cfg,  32'h0);
        checkOutput("rst busy", bus.busy, 1'b0);
        checkOutput("rst err",  bus.err,  1'b0);
        checkOutput("rst done", bus.done, 1'b0);
        checkOutput("rst sdo",  bus.sdo,  1'b0);

        $display("[TB] first commit, pin 2 = {A5,oe=1,ie=0}");
        shiftBits(imgA, 40);
        checkOutput("A sdo after shift", bus.sdo, 1'b1);
        checkOutput("A oe before commit", bus.oe, 4'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("A busy c1", bus.busy, 1'b1);
        checkOutput("A done c1", bus.done, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("A busy c2", bus.busy, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("A busy c3", bus.busy, 1'b1);
        checkOutput("A cfg c3",  bus.cfg,  32'h0);
        checkOutput("A done c3", bus.done, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("A busy c4",   bus.busy,        1'b0);
        checkOutput("A done c4",   bus.done,        1'b1);
        checkOutput("A oe c4",     bus.oe,          4'b0100);
        checkOutput("A ie c4",     bus.ie,          4'b1011);
        checkOutput("A cfg2 c4",   bus.cfg[23:16],  8'hA5);
        checkOutput("A cfg c4",    bus.cfg,         32'h00A50000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("A done c5",   bus.done,        1'b0);

        $display("[TB] enable pin 0, then reprogram pin 2 cfg");
        commitImage(imgA2);
        checkOutput("A2 oe",  bus.oe,  4'b0101);
        checkOutput("A2 cfg", bus.cfg, 32'h00A50011);
        shiftBits(imgB, 40);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("B oe c1", bus.oe, 4'b0001);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("B oe c2", bus.oe, 4'b0001);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("B oe c3",  bus.oe,  4'b0001);
        checkOutput("B cfg c3", bus.cfg, 32'h00A50011);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("B oe c4",   bus.oe,   4'b0101);
        checkOutput("B cfg c4",  bus.cfg,  32'h003C0011);
        checkOutput("B done c4", bus.done, 1'b1);

        $display("[TB] short load sets err, good load clears it");
        shiftBits(imgC, 39);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("C39 err",  bus.err,  1'b1);
        checkOutput("C39 busy", bus.busy, 1'b0);
        checkOutput("C39 oe",   bus.oe,   4'b0101);
        checkOutput("C39 cfg",  bus.cfg,  32'h003C0011);
        shiftBits(imgC, 40);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("C busy c1", bus.busy, 1'b1);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("C err c3", bus.err, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("C err c4",  bus.err,  1'b0);
        checkOutput("C done c4", bus.done, 1'b1);
        checkOutput("C cfg c4",  bus.cfg,  32'h003C5A11);
        checkOutput("C ie c4",   bus.ie,   4'b1011);

        $display("[TB] overshift sets err");
        shiftBits(imgC, 41);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("C41 err",  bus.err,  1'b1);
        checkOutput("C41 busy", bus.busy, 1'b0);

        $display("[TB] shift with update, shift while busy");
        shiftBits(imgD, 40);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("D busy c1", bus.busy, 1'b1);
        checkOutput("D sdo c1",  bus.sdo,  1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("D sdo c2",  bus.sdo,  1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("D sdo c3",  bus.sdo,  1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("D sdo c4",  bus.sdo,  1'b1);
        checkOutput("D done c4", bus.done, 1'b1);
        checkOutput("D oe c4",   bus.oe,   4'b0100);
        checkOutput("D cfg c4",  bus.cfg,  32'h003C5A11);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("D sdo bit1", bus.sdo, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("D sdo bit2", bus.sdo, 1'b1);

        $display("[TB] reset during commit");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("E pre err", bus.err, 1'b1);
        shiftBits(imgE, 40);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("E busy c1", bus.busy, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #2;
        checkOutput("E rst ie",   bus.ie,   4'hF);
        checkOutput("E rst oe",   bus.oe,   4'h0);
        checkOutput("E rst cfg",  bus.cfg,  32'h0);
        checkOutput("E rst busy", bus.busy, 1'b0);
        checkOutput("E rst err",  bus.err,  1'b0);
        checkOutput("E rst sdo",  bus.sdo,  1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("E post oe",   bus.oe,   4'h0);
        checkOutput("E post cfg",  bus.cfg,  32'h0);
        checkOutput("E post ie",   bus.ie,   4'hF);
        checkOutput("E post done", bus.done, 1'b0);
        checkOutput("E post busy", bus.busy, 1'b0);

        $display("[TB] capture behaviour");
        commitImage(imgF);
        checkOutput("F done", bus.done, 1'b1);
        checkOutput("F cfg",  bus.cfg,  32'h81422418);
        checkOutput("F oe",   bus.oe,   4'b0101);
        checkOutput("F ie",   bus.ie,   4'b1001);
`ifdef LA_IOCFG_READBACK_EN
        shiftBits(40'h0, 5);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            checkOutput($sformatf("F readback bit %0d", i), bus.sdo, imgF[i]);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("F recommit busy", bus.busy, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("F recommit done", bus.done, 1'b1);
        checkOutput("F recommit err",  bus.err,  1'b0);
        checkOutput("F recommit cfg",  bus.cfg,  32'h81422418);
`else
        shiftBits(40'h0, 3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("F capture ignored sdo", bus.sdo, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("F capture ignored err",  bus.err,  1'b1);
        checkOutput("F capture ignored busy", bus.busy, 1'b0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/la_iocfg_loader.md
# la_iocfg_loader

Serial configuration loader for the padring's per-pin `ie`/`oe`/`cfg` controls, generalised to any pin count and config width. It sits between a low-pin-count configuration source (JTAG user register, boot FSM, test controller) and the side-level pad instances. It holds a shadow chain and a registered active copy of every pin's controls. Commits are break-before-make: the output enables of changed pins are forced off for a programmable hold before new values apply.

## Interface
Parameters:
- `NPINS`, 4, total pins served (all sides concatenated, pin 0 first)
- `CFGW`, 8, per-pin generic config width
- `HOLDCYC`, 2, quiesce cycles before apply; legal range ≥1
- Derived: `RECW = CFGW+2`, `LEN = NPINS*RECW`

Ports:
- `clk`, in, 1, single clock
- `reset`, in, 1, asynchronous, active-high
- `shift_en`, in, 1, shift one bit per cycle
- `sdi`, in, 1, serial data in
- `sdo`, out, 1, serial data out = shadow[0]
- `update`, in, 1, request commit (level sampled per cycle)
- `capture`, in, 1, load active into shadow (see Configuration)
- `busy`, out, 1, high in QUIESCE/APPLY
- `done`, out, 1, one-cycle pulse after commit
- `err`, out, 1, sticky: update with wrong bit count
- `ie`, out, NPINS, input enables to pads
- `oe`, out, NPINS, output enables to pads
- `cfg`, out, NPINS*CFGW, config to pads

## Operation
- Record layout: pin p at shadow[p*RECW +: RECW] = {cfg[CFGW-1:0], oe, ie}, with ie at bit 0.
- Shift (IDLE, `shift_en`=1, `update`=0): shadow <= {sdi, shadow[LEN-1:1]}, LSB shifted out first. Bit count increments, saturating at LEN+1 so overshift is detectable.
- FSM states: IDLE, QUIESCE, APPLY.
- IDLE + `update`, count==LEN: go to QUIESCE. mask[p] <= 1 for every pin whose shadow record ≠ active record. Hold counter <= HOLDCYC-1.
- IDLE + `update`, count≠LEN: `err` <= 1, count <= 0, no commit, stay IDLE.
- QUIESCE: decrement the hold counter. At 0, go to APPLY.
- APPLY: active <= shadow, mask <= 0, count <= 0, `err` <= 0, `done` <= 1, then IDLE.
- `oe` = active_oe & ~mask. `ie` and `cfg` come straight from active registers, unchanged during quiesce.
- `update` and `shift_en` in the same IDLE cycle: update wins and the shift is dropped.
- `shift_en`, `update` and `capture` are ignored while `busy`. The shadow is frozen during a commit.
- `reset` mid-commit: immediate return to IDLE with reset values. A partial commit is never visible.

## Timing
- Reset values: `ie`=all 1, `oe`=all 0, `cfg`=all 0, shadow=0, `sdo`=0, `busy`=0, `done`=0, `err`=0, count=0, mask=0, state IDLE.
- All outputs are registered, or are an AND of registers; no combinational input-to-output path.
- `update` sampled high in cycle 0:
  - `busy` and mask are visible cycles 1..HOLDCYC+1.
  - New active values and `done` are visible in cycle HOLDCYC+2.
  - `busy` is low in cycle HOLDCYC+2.
- `err` is visible the cycle after the bad `update`. It stays set until the next successful APPLY or reset.
- Shifting: `sdo` reflects the new shadow[0] one cycle after each `shift_en`.

## Configuration
- `LA_IOCFG_READBACK_EN` defined:
  - `capture` in IDLE loads shadow <= active and count <= LEN, so a plain `update` recommits unchanged values.
  - `capture` with `update` in the same cycle: `update` wins.
- Undefined: `capture` is ignored, and the shadow only changes by shifting or reset.

## Structure
- Package `la_iocfg_pkg` holds:
  - the state encoding (IDLE/QUIESCE/APPLY)
  - the RECW/LEN computation
  - record field offsets (IE_BIT=0, OE_BIT=1, CFG_LSB=2)
- Sub-module `la_iocfg_chain` contains the shadow shift register, the saturating bit counter, and the capture mux. The top level holds the FSM, the hold counter, the mask, and the active registers.

## Test plan
All scenarios use NPINS=4, CFGW=8 (LEN=40) and HOLDCYC=2.
- Reset: outputs `ie`=4'hF, `oe`=0, `cfg`=0, `busy`=0, `err`=0.
- Shift 40 bits setting pin 2 to {cfg=8'hA5, oe=1, ie=0}, then `update`:
  - `busy` high cycles 1–3.
  - `done` and `oe`=4'b0100 in cycle 4.
  - `cfg[23:16]`=8'hA5 in cycle 4.
- With pin 2 oe=1, reprogram pin 2 cfg to 8'h3C: `oe[2]`=0 during cycles 1–3, back to 1 in cycle 4. Pins with unchanged records keep their `oe` throughout.
- Shift 39 bits then `update`: `err`=1 the next cycle, outputs unchanged, count cleared. A subsequent correct 40-bit load plus `update` commits and clears `err`.
- `shift_en` and `update` together, and `shift_en` while `busy`: shadow is unchanged (check `sdo` sequence). `reset` asserted in cycle 2 of a commit: reset values, no partial apply.
- With `LA_IOCFG_READBACK_EN`, after a commit pulse `capture` then shift 40 bits: `sdo` stream equals the active records, pin 0 ie first.
